top_level_module: RTL and testbench

TOP_LEVEL_MODULE -- requirements
Module: top_level_module

---
 rtl/top_level_module_pkg.sv | 39 +++
 rtl/top_level_module_bcd_mod60_counter.sv | 29 ++
 rtl/top_level_module.sv | 77 +++++++
 tb/tb_top_level_module.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/top_level_module_pkg.sv
// Shared constants, time record and BCD helpers for the 12-hour digital clock.
package top_level_module_pkg;

  localparam int TICKS_PER_SEC_DEF = 100000;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h12;
  localparam logic [7:0] HR_MIN  = 8'h01;

  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
  } bcd_time_t;

  localparam bcd_time_t RESET_TIME = '{hour: 8'h12, minute: 8'h00, second: 8'h00};

  // Both nibbles must be decimal digits
  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic is_mod60(input logic [7:0] v);
    return is_bcd(v) && (v <= SEC_MAX);
  endfunction

  // Valid BCD is ordered like binary, so plain byte compares bound the range
  function automatic logic is_hour(input logic [7:0] v);
    return is_bcd(v) && (v >= HR_MIN) && (v <= HR_MAX);
  endfunction

  // 12 -> 01, x9 -> (x+1)0, otherwise bump units
  function automatic logic [7:0] hour_next(input logic [7:0] h);
    if (h == HR_MAX)        return HR_MIN;
    else if (h[3:0] == 4'd9) return {h[7:4] + 4'd1, 4'd0};
    else                     return {h[7:4], h[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/top_level_module_bcd_mod60_counter.sv
// Packed-BCD 00..59 counter with synchronous load and a carry on the 59 -> 00 step.
module bcd_mod60_counter
  import top_level_module_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic [7:0] val,
  output logic       carry
);

  assign carry = en && (val == SEC_MAX);

  // Load wins over enable; enable steps the BCD count and wraps at 59
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           val <= RST_VAL;
    else if (load)        val <= load_val;
    else if (en) begin
      if (carry)                val <= 8'h00;
      else if (val[3:0] == 4'd9) val <= {val[7:4] + 4'd1, 4'd0};
      else                      val <= {val[7:4], val[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/top_level_module.sv
// 12-hour BCD clock: one-second prescaler, sec/min counters, hour and AM/PM state.
module top_level_module
  import top_level_module_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkGenRst,
  input  logic        set,
  input  logic [7:0]  hr,
  input  logic [7:0]  min,
  input  logic [7:0]  sec,
  input  logic        dayNight,
  output logic        AM,
  output logic [23:0] digi_clock
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [PW-1:0] presc;
  logic          tick, set_ok, adv;
  logic          sec_carry, min_carry;
  logic [7:0]    sec_q, min_q, hr_q;
  logic          am_q;

  // Assert asynchronously, release two clocks after reset goes high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // A load with any out-of-range field behaves as if set were low
  assign set_ok = set && is_hour(hr) && is_mod60(min) && is_mod60(sec);
  assign tick   = !clkGenRst && (presc == PRESC_MAX);
  assign adv    = tick && !set_ok;

  // Prescaler: cleared by a load or by clkGenRst, otherwise wraps on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    presc <= '0;
    else if (set_ok || clkGenRst)  presc <= '0;
    else if (tick)                 presc <= '0;
    else                           presc <= presc + PW'(1);
  end

  bcd_mod60_counter #(.RST_VAL(RESET_TIME.second)) u_sec (
    .clk(clk), .rst_n(rst_n), .load(set_ok), .load_val(sec),
    .en(adv), .val(sec_q), .carry(sec_carry)
  );

  bcd_mod60_counter #(.RST_VAL(RESET_TIME.minute)) u_min (
    .clk(clk), .rst_n(rst_n), .load(set_ok), .load_val(min),
    .en(sec_carry), .val(min_q), .carry(min_carry)
  );

  // Hours follow 12,01..11; meridiem flips only on the 11 -> 12 step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_q <= RESET_TIME.hour;
      am_q <= 1'b1;
    end else if (set_ok) begin
      hr_q <= hr;
      am_q <= ~dayNight;
    end else if (min_carry) begin
      hr_q <= hour_next(hr_q);
      if (hr_q == 8'h11) am_q <= ~am_q;
    end
  end

  assign digi_clock = {hr_q, min_q, sec_q};
  assign AM         = am_q;

endmodule

// File: tb/tb_top_level_module.sv
// Directed bench for the 12-hour clock with a 4-cycle second.
module tb_top_level_module;

  logic        clk = 1'b0;
  logic        reset, clkGenRst, set, dayNight;
  logic [7:0]  hr, min, sec;
  logic        AM;
  logic [23:0] digi_clock;

  int n_tests = 0;
  int n_fail  = 0;

  top_level_module #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .reset(reset), .clkGenRst(clkGenRst), .set(set),
    .hr(hr), .min(min), .sec(sec), .dayNight(dayNight),
    .AM(AM), .digi_clock(digi_clock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  hr, min, sec;
    logic        dn;
    logic [23:0] exp_tick;
    logic        exp_am;
  } vec_t;

  vec_t vecs[8];

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [24:0] exp);
    n_tests++;
    if ($isunknown({AM, digi_clock}) || {AM, digi_clock} !== exp) begin
      n_fail++;
      $display("FAIL %s: got AM=%b clock=%h, want AM=%b clock=%h",
               name, AM, digi_clock, exp[24], exp[23:0]);
    end
  endtask

  task automatic load(input logic [7:0] h, m, s, input logic dn);
    hr = h; min = m; sec = s; dayNight = dn; set = 1'b1;
    step(1);
    set = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h06, 8'h40, 8'h30, 1'b0, 24'h064031, 1'b1};
    vecs[1] = '{8'h11, 8'h59, 8'h59, 1'b0, 24'h120000, 1'b0};
    vecs[2] = '{8'h12, 8'h59, 8'h59, 1'b1, 24'h010000, 1'b0};
    vecs[3] = '{8'h11, 8'h59, 8'h59, 1'b1, 24'h120000, 1'b1};
    vecs[4] = '{8'h09, 8'h59, 8'h59, 1'b0, 24'h100000, 1'b1};
    vecs[5] = '{8'h12, 8'h00, 8'h59, 1'b0, 24'h120100, 1'b1};
    vecs[6] = '{8'h01, 8'h09, 8'h59, 1'b1, 24'h011000, 1'b0};
    vecs[7] = '{8'h10, 8'h59, 8'h59, 1'b1, 24'h110000, 1'b0};

    reset = 1'b0; clkGenRst = 1'b0; set = 1'b0; dayNight = 1'b0;
    hr = 8'h00; min = 8'h00; sec = 8'h00;

    // Reset: internal release lands two edges after reset rises, then one
    // full 4-cycle second elapses before the first increment.
    step(2);
    chk("reset_low", {1'b1, 24'h120000});
    reset = 1'b1;
    step(5);
    chk("reset_hold", {1'b1, 24'h120000});
    step(1);
    chk("reset_first_sec", {1'b1, 24'h120001});

    // Table: load, check the loaded value, then one second later the rolled value
    for (int i = 0; i < 8; i++) begin
      load(vecs[i].hr, vecs[i].min, vecs[i].sec, vecs[i].dn);
      chk($sformatf("vec%0d_load", i),
          {~vecs[i].dn, vecs[i].hr, vecs[i].min, vecs[i].sec});
      step(3);
      chk($sformatf("vec%0d_pre", i),
          {~vecs[i].dn, vecs[i].hr, vecs[i].min, vecs[i].sec});
      step(1);
      chk($sformatf("vec%0d_tick", i), {vecs[i].exp_am, vecs[i].exp_tick});
    end

    // Illegal loads are ignored and do not clear the prescaler
    load(8'h06, 8'h40, 8'h30, 1'b0);
    chk("ill_base", {1'b1, 24'h064030});
    load(8'h13, 8'h00, 8'h00, 1'b1);
    chk("ill_hr13", {1'b1, 24'h064030});
    load(8'h05, 8'h00, 8'h5A, 1'b1);
    chk("ill_sec5A", {1'b1, 24'h064030});
    step(1);
    chk("ill_presc_kept", {1'b1, 24'h064030});
    step(1);
    chk("ill_tick", {1'b1, 24'h064031});
    load(8'h00, 8'h00, 8'h00, 1'b1);
    chk("ill_hr00", {1'b1, 24'h064031});
    load(8'h03, 8'h60, 8'h00, 1'b1);
    chk("ill_min60", {1'b1, 24'h064031});

    // clkGenRst freezes time; set still loads while it is high
    load(8'h06, 8'h40, 8'h30, 1'b0);
    clkGenRst = 1'b1;
    step(20);
    chk("cgr_frozen", {1'b1, 24'h064030});
    load(8'h02, 8'h15, 8'h00, 1'b1);
    chk("cgr_set", {1'b0, 24'h021500});
    step(5);
    chk("cgr_frozen2", {1'b0, 24'h021500});
    clkGenRst = 1'b0;
    step(3);
    chk("cgr_release_pre", {1'b0, 24'h021500});
    step(1);
    chk("cgr_release_tick", {1'b0, 24'h021501});

    // set beats a coincident tick; holding set keeps time frozen
    load(8'h06, 8'h40, 8'h30, 1'b0);
    step(3);
    hr = 8'h03; min = 8'h00; sec = 8'h00; dayNight = 1'b0; set = 1'b1;
    step(1);
    chk("prio_load", {1'b1, 24'h030000});
    step(9);
    chk("hold_set", {1'b1, 24'h030000});
    set = 1'b0;
    step(3);
    chk("hold_release_pre", {1'b1, 24'h030000});
    step(1);
    chk("hold_release_tick", {1'b1, 24'h030001});

    // Reset during an active load wins immediately, without a clock edge
    hr = 8'h06; min = 8'h40; sec = 8'h30; dayNight = 1'b1; set = 1'b1;
    step(1);
    chk("rst_set_loaded", {1'b0, 24'h064030});
    #2 reset = 1'b0;
    #1 chk("rst_over_set", {1'b1, 24'h120000});
    step(2);
    chk("rst_over_set_hold", {1'b1, 24'h120000});
    set = 1'b0;
    reset = 1'b1;
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
